// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : RV64I fetch front end. Issues word-aligned fetches, buffers
//               in-order responses in a FIFO, and flushes on PC redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  input  logic        instr_ready
);

  localparam int unsigned c_aw = $clog2(DEPTH);
  localparam int unsigned c_cw = c_aw + 1;
  localparam logic [c_cw:0]   c_credit_lim = (c_cw + 1)'(DEPTH);
  localparam logic [c_cw-1:0] c_full       = c_cw'(DEPTH);
  localparam logic [31:0]     c_nop        = 32'h00000013;

  logic [63:0]     r_fetch_pc;
  logic [63:0]     r_rsp_pc;
  logic [c_cw-1:0] r_outstanding;
  logic [c_cw-1:0] r_drop;
  logic [c_cw-1:0] r_count;
  logic [c_aw-1:0] r_wptr;
  logic [c_aw-1:0] r_rptr;
  logic [63:0]     r_pc_mem  [DEPTH];
  logic [31:0]     r_ins_mem [DEPTH];

  logic [c_cw:0]   w_credit_used;
  logic            w_req_valid;
  logic            w_accept;
  logic            w_rsp;
  logic            w_push;
  logic            w_instr_valid;
  logic            w_pop;
  logic [c_cw-1:0] w_out_next;
  logic [63:0]     w_redirect_pc;

  // Outstanding fetches plus buffered entries may never exceed the FIFO size,
  // which is what makes a push into a full FIFO impossible.
  assign w_credit_used = {1'b0, r_outstanding} + {1'b0, r_count};
  assign w_req_valid   = rst & ~redirect_valid & (w_credit_used < c_credit_lim);
  assign w_accept      = w_req_valid & imem_req_ready;
  assign w_rsp         = rst & imem_rsp_valid;
  assign w_push        = w_rsp & ~redirect_valid & (r_drop == '0);
  assign w_instr_valid = rst & (r_count != '0) & ~redirect_valid;
  assign w_pop         = w_instr_valid & instr_ready;
  assign w_out_next    = r_outstanding + c_cw'(w_accept) - c_cw'(w_rsp);
  assign w_redirect_pc = redirect_pc & ~64'd3;

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign instr_valid    = w_instr_valid;
  assign instr          = w_instr_valid ? r_ins_mem[r_rptr] : c_nop;
  assign instr_pc       = w_instr_valid ? r_pc_mem[r_rptr]  : 64'd0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (redirect_valid) begin
        r_fetch_pc <= w_redirect_pc;
        r_rsp_pc   <= w_redirect_pc;
        r_count    <= '0;
        r_wptr     <= '0;
        r_rptr     <= '0;
        // Every fetch still in flight after this cycle belongs to the old path.
        r_drop     <= w_out_next;
      end else begin
        if (w_accept) begin
          r_fetch_pc <= r_fetch_pc + 64'd4;
        end
        if (w_rsp && (r_drop != '0)) begin
          r_drop <= r_drop - c_cw'(1);
        end
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + 64'd4;
          r_wptr   <= r_wptr + c_aw'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + c_aw'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + c_cw'(1);
          2'b01:   r_count <= r_count - c_cw'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wptr]  <= r_rsp_pc;
      r_ins_mem[r_wptr] <= imem_rsp_data;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
    !(w_push && (r_count == c_full)));

  a_drop_within_outstanding: assert property (@(posedge clk) disable iff (!rst)
    r_drop <= r_outstanding);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// Testbench for instr_fetch_unit: directed scenarios plus a randomized run
// scored against an address-stream model of the fetch front end.
module tb_instr_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'd0;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_ready;

  always #5 clk = ~clk;

  instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  typedef struct { logic [63:0] addr; int due; } req_t;
  req_t pend[$];
  int   cyc = 0;
  int   last_due = 0;
  int   mem_lat = 1;
  bit   rand_lat = 1'b0;
  int   n_total = 0;
  int   n_pass = 0;

  logic        s_req_valid, s_instr_valid, s_rsp_valid;
  logic [63:0] s_req_addr, s_instr_pc;
  logic [31:0] s_instr;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] + 32'h100;
  endfunction

  // One clock cycle: memory drives its response, outputs are sampled 1ns later,
  // then the memory model advances at the posedge. Returns at the next negedge.
  task automatic tick();
    req_t r;
    int   lat;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    #1;
    s_req_valid   = imem_req_valid;
    s_req_addr    = imem_req_addr;
    s_instr_valid = instr_valid;
    s_instr       = instr;
    s_instr_pc    = instr_pc;
    s_rsp_valid   = imem_rsp_valid;
    @(posedge clk);
    if (!rst) begin
      pend.delete();
      last_due = 0;
    end else begin
      if (s_rsp_valid) void'(pend.pop_front());
      if (s_req_valid && imem_req_ready) begin
        lat = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
        r.addr = s_req_addr;
        r.due  = cyc + lat;
        if (r.due <= last_due) r.due = last_due + 1;
        last_due = r.due;
        pend.push_back(r);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0; imem_req_ready = 1'b0;
    rand_lat = 1'b0; mem_lat = 1;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b1; imem_req_ready = 1'b1;
    tick(); tick();
    n_total++; if (s_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %0b want 0", s_req_valid); else n_pass++;
    n_total++; if (s_instr_valid !== 1'b0) $display("FAIL reset_instr_valid: got %0b want 0", s_instr_valid); else n_pass++;
    n_total++; if (s_instr !== NOP) $display("FAIL reset_instr: got %h want %h", s_instr, NOP); else n_pass++;
    n_total++; if (s_instr_pc !== 64'd0) $display("FAIL reset_instr_pc: got %h want 0", s_instr_pc); else n_pass++;
  endtask

  task automatic test_free_run();
    logic [63:0] epc;
    rst = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b1; mem_lat = 1;
    for (int k = 0; k < 12; k++) begin
      tick();
      n_total++;
      if (s_req_valid !== 1'b1 || s_req_addr !== 64'(4 * k))
        $display("FAIL free_req cyc%0d: got v=%0b a=%h want v=1 a=%h", k, s_req_valid, s_req_addr, 64'(4 * k));
      else n_pass++;
      if (k >= 2) begin
        epc = 64'(4 * (k - 2));
        n_total++;
        if (s_instr_valid !== 1'b1 || s_instr_pc !== epc || s_instr !== mem_word(epc))
          $display("FAIL free_instr cyc%0d: got v=%0b pc=%h i=%h want v=1 pc=%h i=%h",
                   k, s_instr_valid, s_instr_pc, s_instr, epc, mem_word(epc));
        else n_pass++;
      end else begin
        n_total++;
        if (s_instr_valid !== 1'b0 || s_instr !== NOP || s_instr_pc !== 64'd0)
          $display("FAIL free_idle cyc%0d: got v=%0b pc=%h i=%h want v=0 pc=0 i=%h",
                   k, s_instr_valid, s_instr_pc, s_instr, NOP);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] addrs[$];
    logic [63:0] pops[$];
    logic [63:0] first_req;
    bit          got_req;
    do_reset();
    imem_req_ready = 1'b1; instr_ready = 1'b0; mem_lat = 1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (s_req_valid && imem_req_ready) addrs.push_back(s_req_addr);
    end
    n_total++; if (addrs.size() != DEPTH) $display("FAIL bp_req_count: got %0d want %0d", addrs.size(), DEPTH); else n_pass++;
    for (int i = 0; i < DEPTH && i < addrs.size(); i++) begin
      n_total++; if (addrs[i] !== 64'(4 * i)) $display("FAIL bp_req_addr%0d: got %h want %h", i, addrs[i], 64'(4 * i)); else n_pass++;
    end
    n_total++; if (s_req_valid !== 1'b0) $display("FAIL bp_req_stalled: got %0b want 0", s_req_valid); else n_pass++;
    n_total++; if (s_instr_valid !== 1'b1) $display("FAIL bp_head_valid: got %0b want 1", s_instr_valid); else n_pass++;
    instr_ready = 1'b1;
    got_req = 1'b0; first_req = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (s_instr_valid) pops.push_back(s_instr_pc);
      if (s_req_valid && !got_req) begin got_req = 1'b1; first_req = s_req_addr; end
    end
    n_total++; if (pops.size() < 4) $display("FAIL bp_pop_count: got %0d want >=4", pops.size()); else n_pass++;
    for (int i = 0; i < 4 && i < pops.size(); i++) begin
      n_total++; if (pops[i] !== 64'(4 * i)) $display("FAIL bp_pop_pc%0d: got %h want %h", i, pops[i], 64'(4 * i)); else n_pass++;
    end
    n_total++; if (!got_req || first_req !== 64'd16) $display("FAIL bp_resume_addr: got %h (seen=%0b) want 10", first_req, got_req); else n_pass++;
  endtask

  task automatic test_redirect_inflight();
    logic [63:0] pops[$];
    logic [31:0] first_ins;
    logic [63:0] first_req;
    bit          got_req;
    do_reset();
    imem_req_ready = 1'b1; instr_ready = 1'b1; mem_lat = 3;
    for (int k = 0; k < 10 && pend.size() < 2; k++) tick();
    n_total++; if (pend.size() != 2) $display("FAIL rd_setup_outstanding: got %0d want 2", pend.size()); else n_pass++;
    redirect_valid = 1'b1; redirect_pc = 64'h2002;
    tick();
    n_total++; if (s_req_valid !== 1'b0 || s_instr_valid !== 1'b0)
      $display("FAIL rd_cycle_quiet: got req=%0b iv=%0b want 0 0", s_req_valid, s_instr_valid); else n_pass++;
    redirect_valid = 1'b0;
    got_req = 1'b0; first_req = '0; first_ins = '0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (s_req_valid && imem_req_ready && !got_req) begin got_req = 1'b1; first_req = s_req_addr; end
      if (s_instr_valid) begin
        if (pops.size() == 0) first_ins = s_instr;
        pops.push_back(s_instr_pc);
      end
    end
    n_total++; if (!got_req || first_req !== 64'h2000) $display("FAIL rd_first_req: got %h want 2000", first_req); else n_pass++;
    n_total++; if (pops.size() < 2) $display("FAIL rd_pop_count: got %0d want >=2", pops.size()); else n_pass++;
    if (pops.size() >= 2) begin
      n_total++; if (pops[0] !== 64'h2000 || pops[1] !== 64'h2004)
        $display("FAIL rd_pop_pcs: got %h %h want 2000 2004", pops[0], pops[1]); else n_pass++;
      n_total++; if (first_ins !== 32'h2100) $display("FAIL rd_first_instr: got %h want 2100", first_ins); else n_pass++;
    end
  endtask

  task automatic test_redirect_coincident();
    logic [63:0] first_pop;
    bit          got_pop;
    do_reset();
    imem_req_ready = 1'b1; instr_ready = 1'b0; mem_lat = 1;
    for (int k = 0; k < 3; k++) tick();
    redirect_valid = 1'b1; redirect_pc = 64'h400; instr_ready = 1'b1;
    tick();
    n_total++; if (s_rsp_valid !== 1'b1) $display("FAIL co_setup_rsp: got %0b want 1", s_rsp_valid); else n_pass++;
    n_total++; if (s_instr_valid !== 1'b0 || s_req_valid !== 1'b0 || s_instr !== NOP)
      $display("FAIL co_cycle: got iv=%0b req=%0b i=%h want 0 0 %h", s_instr_valid, s_req_valid, s_instr, NOP); else n_pass++;
    redirect_valid = 1'b0;
    tick();
    n_total++; if (s_instr_valid !== 1'b0) $display("FAIL co_flushed: got iv=%0b want 0", s_instr_valid); else n_pass++;
    n_total++; if (s_req_valid !== 1'b1 || s_req_addr !== 64'h400)
      $display("FAIL co_new_req: got v=%0b a=%h want 1 400", s_req_valid, s_req_addr); else n_pass++;
    got_pop = 1'b0; first_pop = '0;
    for (int k = 0; k < 8 && !got_pop; k++) begin
      tick();
      if (s_instr_valid) begin got_pop = 1'b1; first_pop = s_instr_pc; end
    end
    n_total++; if (!got_pop || first_pop !== 64'h400) $display("FAIL co_first_pop: got %h (seen=%0b) want 400", first_pop, got_pop); else n_pass++;
  endtask

  task automatic test_mid_reset();
    logic [63:0] first_pop;
    logic [31:0] first_ins;
    bit          got_pop;
    do_reset();
    imem_req_ready = 1'b1; instr_ready = 1'b0; mem_lat = 1;
    for (int k = 0; k < 4; k++) tick();
    n_total++; if (pend.size() != 1 || s_instr_valid !== 1'b1)
      $display("FAIL mr_setup: got outstanding=%0d iv=%0b want 1 1", pend.size(), s_instr_valid); else n_pass++;
    rst = 1'b0;
    tick();
    n_total++; if (s_req_valid !== 1'b0 || s_instr_valid !== 1'b0 || s_instr !== NOP || s_instr_pc !== 64'd0)
      $display("FAIL mr_in_reset: got req=%0b iv=%0b i=%h pc=%h want 0 0 %h 0", s_req_valid, s_instr_valid, s_instr, s_instr_pc, NOP);
    else n_pass++;
    rst = 1'b1;
    tick();
    n_total++; if (s_req_valid !== 1'b1 || s_req_addr !== RESET_PC)
      $display("FAIL mr_req: got v=%0b a=%h want 1 %h", s_req_valid, s_req_addr, RESET_PC); else n_pass++;
    n_total++; if (s_instr_valid !== 1'b0 || s_instr !== NOP || s_instr_pc !== 64'd0)
      $display("FAIL mr_head: got iv=%0b i=%h pc=%h want 0 %h 0", s_instr_valid, s_instr, s_instr_pc, NOP); else n_pass++;
    instr_ready = 1'b1;
    got_pop = 1'b0; first_pop = '0; first_ins = '0;
    for (int k = 0; k < 8 && !got_pop; k++) begin
      tick();
      if (s_instr_valid) begin got_pop = 1'b1; first_pop = s_instr_pc; first_ins = s_instr; end
    end
    n_total++; if (!got_pop || first_pop !== RESET_PC || first_ins !== mem_word(RESET_PC))
      $display("FAIL mr_first_pop: got pc=%h i=%h want %h %h", first_pop, first_ins, RESET_PC, mem_word(RESET_PC)); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [63:0] reqs[$];
    logic [63:0] pcs[$];
    logic [31:0] ins[$];
    do_reset();
    imem_req_ready = 1'b1; instr_ready = 1'b1; mem_lat = 1;
    for (int k = 0; k < 3; k++) tick();
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (s_req_valid && imem_req_ready) reqs.push_back(s_req_addr);
      if (s_instr_valid) begin pcs.push_back(s_instr_pc); ins.push_back(s_instr); end
    end
    n_total++; if (reqs.size() < 2 || reqs[0] !== 64'hFFFF_FFFF_FFFF_FFFC || reqs[1] !== 64'd0)
      $display("FAIL wrap_req: got %0d reqs first=%h want FFFFFFFFFFFFFFFC then 0", reqs.size(), reqs.size() > 0 ? reqs[0] : 64'd0);
    else n_pass++;
    n_total++; if (pcs.size() < 2 || pcs[0] !== 64'hFFFF_FFFF_FFFF_FFFC || pcs[1] !== 64'd0 ||
                   ins[0] !== 32'h0000_00FC || ins[1] !== 32'h0000_0100)
      $display("FAIL wrap_pop: got %0d pops first=%h want FFFFFFFFFFFFFFFC/000000FC then 0/00000100",
               pcs.size(), pcs.size() > 0 ? pcs[0] : 64'd0);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [63:0] exp_fetch, exp_pop;
    bit          prev_stall;
    int          npops;
    do_reset();
    rand_lat = 1'b1;
    exp_fetch = RESET_PC; exp_pop = RESET_PC; prev_stall = 1'b0; npops = 0;
    for (int k = 0; k < 600; k++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = {$urandom, $urandom};
      tick();
      if (redirect_valid) begin
        n_total++; if (s_req_valid !== 1'b0 || s_instr_valid !== 1'b0)
          $display("FAIL rnd_redirect_quiet cyc%0d: got req=%0b iv=%0b want 0 0", k, s_req_valid, s_instr_valid); else n_pass++;
        exp_fetch = redirect_pc & ~64'd3;
        exp_pop   = redirect_pc & ~64'd3;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          n_total++; if (s_req_valid !== 1'b1) $display("FAIL rnd_req_hold cyc%0d: got %0b want 1", k, s_req_valid); else n_pass++;
        end
        if (s_req_valid && imem_req_ready) begin
          n_total++; if (s_req_addr !== exp_fetch) $display("FAIL rnd_req_addr cyc%0d: got %h want %h", k, s_req_addr, exp_fetch); else n_pass++;
          exp_fetch += 64'd4;
        end
        if (s_instr_valid) begin
          if (instr_ready) begin
            n_total++; if (s_instr_pc !== exp_pop || s_instr !== mem_word(exp_pop))
              $display("FAIL rnd_pop cyc%0d: got pc=%h i=%h want %h %h", k, s_instr_pc, s_instr, exp_pop, mem_word(exp_pop));
            else n_pass++;
            exp_pop += 64'd4;
            npops++;
          end
        end else begin
          n_total++; if (s_instr !== NOP || s_instr_pc !== 64'd0)
            $display("FAIL rnd_idle_head cyc%0d: got i=%h pc=%h want %h 0", k, s_instr, s_instr_pc, NOP); else n_pass++;
        end
        prev_stall = s_req_valid && !imem_req_ready;
      end
      n_total++; if (pend.size() > DEPTH) $display("FAIL rnd_credit cyc%0d: got %0d outstanding want <=%0d", k, pend.size(), DEPTH); else n_pass++;
    end
    redirect_valid = 1'b0;
    n_total++; if (npops < 50) $display("FAIL rnd_progress: got %0d pops want >=50", npops); else n_pass++;
  endtask

  initial begin
    rst = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_free_run();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_coincident();
    test_mid_reset();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
